// File: rtl/trig_nco_bank.sv
// trig_nco_bank: multi-bin NCO producing paired sin/cos samples from one shared quarter-wave LUT.
// Latency: 2 cycles from req_valid_i to out_valid_o; accepts one request every cycle.
// Backpressure: none. Optional lookup dither is enabled by defining TRIG_NCO_DITHER_EN.
module trig_nco_bank #(
   parameter int    N        = 16,
   parameter int    BINS     = 24,
   parameter int    PW       = 16,
   parameter int    LUT_AW   = 8,
   parameter string LUT_FILE = "../other/quartersin.txt"
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       sync_i,
   input  logic                       cfg_we_i,
   input  logic                       cfg_sel_i,
   input  logic [$clog2(BINS)-1:0]    cfg_bin_i,
   input  logic [PW-1:0]              cfg_data_i,
   input  logic                       req_valid_i,
   input  logic [$clog2(BINS)-1:0]    req_bin_i,
   input  logic                       req_advance_i,
   output logic                       out_valid_o,
   output logic [$clog2(BINS)-1:0]    out_bin_o,
   output logic signed [N-1:0]        sin_out_o,
   output logic signed [N-1:0]        cos_out_o
);

   localparam int BW    = $clog2(BINS);
   localparam int LUT_N = 2 ** LUT_AW;

   // Quarter-wave table, half-sample offset so that the mirror index is simply ~k.
   // The contents are generated at elaboration from the same formula that produced
   // LUT_FILE, which keeps the ROM self-contained and free of file I/O.
   function automatic logic [N-2:0] quarter_sin(input int k);
      real x, term, acc;
      x    = (real'(k) + 0.5) * 3.14159265358979323846 / real'(2 ** (LUT_AW + 1));
      term = x;
      acc  = x;
      for (int i = 1; i < 10; i++) begin
         term = -term * x * x / real'((2 * i) * (2 * i + 1));
         acc  = acc + term;
      end
      return (N-1)'($rtoi(acc * real'(2 ** (N - 1) - 1) + 0.5));
   endfunction

   logic [N-2:0] lut_rom [LUT_N];
   for (genvar g = 0; g < LUT_N; g++) begin : g_lut
      assign lut_rom[g] = quarter_sin(g);
   end

   logic [PW-1:0] phase_q [BINS];
   logic [PW-1:0] phase_d [BINS];
   logic [PW-1:0] inc_q   [BINS];
   logic [PW-1:0] inc_d   [BINS];

   logic              req_in, cfg_in;
   logic [PW-1:0]     p;
   logic [LUT_AW+1:0] pa;
   logic [1:0]        q, qc;
   logic [LUT_AW-1:0] k, sin_addr, cos_addr;

`ifdef TRIG_NCO_DITHER_EN
   localparam int DW = PW - 2 - LUT_AW;
   logic [15:0] lfsr_q, lfsr_d;

   // Dither LFSR: x^16+x^14+x^13+x^11, steps once per accepted request.
   always_ff @(posedge clk_i) begin
      if (!rst_i) lfsr_q <= 16'hACE1;
      else        lfsr_q <= lfsr_d;
   end
`endif

   // Stage 0: fetch phase, derive quadrant/index for sin and cos, and next bin state.
   always_comb begin
      req_in = int'(req_bin_i) < BINS;
      cfg_in = int'(cfg_bin_i) < BINS;
      p      = req_in ? phase_q[req_bin_i] : '0;
`ifdef TRIG_NCO_DITHER_EN
      lfsr_d = req_valid_i ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
      pa     = (LUT_AW+2)'((p + PW'(lfsr_q[DW-1:0])) >> DW);
`else
      pa     = p[PW-1 -: LUT_AW+2];
`endif
      q        = pa[LUT_AW+1:LUT_AW];
      k        = pa[LUT_AW-1:0];
      qc       = q + 2'd1;
      sin_addr = q[0]  ? ~k : k;
      cos_addr = qc[0] ? ~k : k;

      phase_d = phase_q;
      inc_d   = inc_q;
      // Advance uses the old increment; a same-bin phase write below overrides it.
      if (req_valid_i && req_advance_i && req_in)
         phase_d[req_bin_i] = p + inc_q[req_bin_i];
      if (cfg_we_i && cfg_in) begin
         if (cfg_sel_i) phase_d[cfg_bin_i] = cfg_data_i;
         else           inc_d[cfg_bin_i]   = cfg_data_i;
      end
      if (sync_i) begin
         for (int b = 0; b < BINS; b++) phase_d[b] = '0;
      end
   end

   // Per-bin phase and increment registers.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         phase_q <= '{default: '0};
         inc_q   <= '{default: '0};
      end else begin
         phase_q <= phase_d;
         inc_q   <= inc_d;
      end
   end

   logic              s1_vld_q, s1_zero_q, s1_sin_neg_q, s1_cos_neg_q;
   logic [BW-1:0]     s1_bin_q;
   logic [N-2:0]      s1_sin_mag_q, s1_cos_mag_q;

   // Stage 1: registered LUT reads with sign flags and bin carried alongside.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         s1_vld_q     <= 1'b0;
         s1_zero_q    <= 1'b0;
         s1_sin_neg_q <= 1'b0;
         s1_cos_neg_q <= 1'b0;
         s1_bin_q     <= '0;
         s1_sin_mag_q <= '0;
         s1_cos_mag_q <= '0;
      end else begin
         s1_vld_q <= req_valid_i;
         if (req_valid_i) begin
            s1_zero_q    <= !req_in;
            s1_sin_neg_q <= q[1];
            s1_cos_neg_q <= qc[1];
            s1_bin_q     <= req_bin_i;
            s1_sin_mag_q <= lut_rom[sin_addr];
            s1_cos_mag_q <= lut_rom[cos_addr];
         end
      end
   end

   logic signed [N-1:0] sin_mag, cos_mag, sin_val, cos_val;

   // Sign application; out-of-range requests produce zero samples.
   always_comb begin
      sin_mag = {1'b0, s1_sin_mag_q};
      cos_mag = {1'b0, s1_cos_mag_q};
      sin_val = s1_zero_q ? '0 : (s1_sin_neg_q ? -sin_mag : sin_mag);
      cos_val = s1_zero_q ? '0 : (s1_cos_neg_q ? -cos_mag : cos_mag);
   end

   logic                out_valid_q;
   logic [BW-1:0]       out_bin_q;
   logic signed [N-1:0] sin_q, cos_q;

   // Stage 2: output registers; samples hold when no result is emitted.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         out_valid_q <= 1'b0;
         out_bin_q   <= '0;
         sin_q       <= '0;
         cos_q       <= '0;
      end else begin
         out_valid_q <= s1_vld_q;
         if (s1_vld_q) begin
            out_bin_q <= s1_bin_q;
            sin_q     <= sin_val;
            cos_q     <= cos_val;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_bin_o   = out_bin_q;
   assign sin_out_o   = sin_q;
   assign cos_out_o   = cos_q;

endmodule

// File: tb/tb_trig_nco_bank.sv
// tb_trig_nco_bank: directed and random stimulus for trig_nco_bank against a phase-level model.
// Expected samples come from the sin formula and quadrant rules applied to modelled bin phases.
// Every cycle compares out_valid and, when valid or in reset, bin and both samples.
module tb_trig_nco_bank;
   localparam int N = 16, BINS = 24, PW = 16, LUT_AW = 8, LUT_N = 256;
   localparam real PI = 3.14159265358979323846;

   logic              clk_i = 1'b0;
   logic              rst_i, sync_i, cfg_we_i, cfg_sel_i, req_valid_i, req_advance_i;
   logic [4:0]        cfg_bin_i, req_bin_i;
   logic [PW-1:0]     cfg_data_i;
   logic              out_valid_o;
   logic [4:0]        out_bin_o;
   logic signed [N-1:0] sin_out_o, cos_out_o;

   trig_nco_bank #(.N(N), .BINS(BINS), .PW(PW), .LUT_AW(LUT_AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .sync_i(sync_i), .cfg_we_i(cfg_we_i),
      .cfg_sel_i(cfg_sel_i), .cfg_bin_i(cfg_bin_i), .cfg_data_i(cfg_data_i),
      .req_valid_i(req_valid_i), .req_bin_i(req_bin_i), .req_advance_i(req_advance_i),
      .out_valid_o(out_valid_o), .out_bin_o(out_bin_o),
      .sin_out_o(sin_out_o), .cos_out_o(cos_out_o));

   always #5 clk_i = ~clk_i;

   int total = 0, bad = 0;
   int T [LUT_N];
   int ph_m [BINS];
   int inc_m [BINS];
   int lfsr_m = 16'hACE1;
   bit s1_v = 1'b0;
   int s1_bin = 0, s1_sin = 0, s1_cos = 0;
   bit e_vld;
   int e_bin = 0, e_sin = 0, e_cos = 0;
   int obs_sin[$], obs_cos[$];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Signed sample for a 16-bit phase: top two bits pick the quadrant, next 8 the index.
   function automatic int wave(input int ph);
      int idx, qd, kk;
      idx = ph / 64;
      qd  = idx / LUT_N;
      kk  = idx % LUT_N;
      case (qd)
         0: return T[kk];
         1: return T[LUT_N - 1 - kk];
         2: return -T[kk];
         default: return -T[LUT_N - 1 - kk];
      endcase
   endfunction

   task automatic idle();
      sync_i = 0; cfg_we_i = 0; cfg_sel_i = 0; cfg_bin_i = 0; cfg_data_i = 0;
      req_valid_i = 0; req_bin_i = 0; req_advance_i = 0;
   endtask

   task automatic set_req(input int bin, input bit adv);
      req_valid_i = 1; req_bin_i = 5'(bin); req_advance_i = adv;
   endtask

   task automatic set_cfg(input bit sel, input int bin, input int data);
      cfg_we_i = 1; cfg_sel_i = sel; cfg_bin_i = 5'(bin); cfg_data_i = 16'(data);
   endtask

   // One clock: predict this request's result, clock, check outputs, update model state.
   task automatic cyc();
      bit nv; int nb, ns, nc, ph, cb, fb;
      nv = req_valid_i; nb = int'(req_bin_i); cb = int'(cfg_bin_i); ns = 0; nc = 0;
      if (req_valid_i && nb < BINS) begin
         ph = ph_m[nb];
`ifdef TRIG_NCO_DITHER_EN
         ph = (ph + (lfsr_m % 64)) % 65536;
`endif
         ns = wave(ph);
         nc = wave((ph + 16384) % 65536);
      end
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
         e_vld = 0; e_bin = 0; e_sin = 0; e_cos = 0;
      end else begin
         e_vld = s1_v;
         if (s1_v) begin e_bin = s1_bin; e_sin = s1_sin; e_cos = s1_cos; end
      end
      chk("out_valid", int'(out_valid_o), int'(e_vld));
      if (e_vld || !rst_i) begin
         chk("out_bin", int'(out_bin_o), e_bin);
         chk("sin_out", int'(sin_out_o), e_sin);
         chk("cos_out", int'(cos_out_o), e_cos);
      end
      if (out_valid_o) begin
         obs_sin.push_back(int'(sin_out_o));
         obs_cos.push_back(int'(cos_out_o));
      end
      if (!rst_i) begin
         for (int b = 0; b < BINS; b++) begin ph_m[b] = 0; inc_m[b] = 0; end
         s1_v = 0; lfsr_m = 16'hACE1;
      end else begin
         if (sync_i) begin
            for (int b = 0; b < BINS; b++) ph_m[b] = 0;
         end else begin
            if (nv && req_advance_i && nb < BINS &&
                !(cfg_we_i && cfg_sel_i && cb == nb))
               ph_m[nb] = (ph_m[nb] + inc_m[nb]) % 65536;
            if (cfg_we_i && cfg_sel_i && cb < BINS) ph_m[cb] = int'(cfg_data_i);
         end
         if (cfg_we_i && !cfg_sel_i && cb < BINS) inc_m[cb] = int'(cfg_data_i);
         if (nv) begin
            fb = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
            lfsr_m = ((lfsr_m * 2) + fb) % 65536;
         end
         s1_v = nv; s1_bin = nb; s1_sin = ns; s1_cos = nc;
      end
   endtask

   initial begin
      int exp_s[5], exp_c[5];
      for (int k = 0; k < LUT_N; k++)
         T[k] = $rtoi(32767.0 * $sin((real'(k) + 0.5) * PI / 512.0) + 0.5);
      for (int b = 0; b < BINS; b++) begin ph_m[b] = 0; inc_m[b] = 0; end

      // Reset state.
      idle(); rst_i = 0;
      cyc(); cyc();
      rst_i = 1; cyc();

      // Quarter-turn stepping on bin 0.
      set_cfg(0, 0, 16'h4000); cyc(); idle();
      obs_sin.delete(); obs_cos.delete();
      for (int i = 0; i < 5; i++) begin set_req(0, 1); cyc(); end
      idle(); cyc(); cyc();
      exp_s = '{T[0], T[255], -T[0], -T[255], T[0]};
      exp_c = '{T[255], -T[0], -T[255], T[0], T[255]};
      chk("t1_count", obs_sin.size(), 5);
      for (int i = 0; i < 5 && i < obs_sin.size(); i++) begin
         chk("t1_sin", obs_sin[i], exp_s[i]);
         chk("t1_cos", obs_cos[i], exp_c[i]);
      end

      // Alternating bins 3/7 back to back, 512 requests.
      set_cfg(0, 3, 1); cyc();
      set_cfg(0, 7, 16'h0100); cyc(); idle();
      obs_sin.delete(); obs_cos.delete();
      for (int i = 0; i < 512; i++) begin set_req((i % 2) ? 7 : 3, 1); cyc(); end
      idle(); cyc(); cyc();
      chk("t2_count", obs_sin.size(), 512);
      obs_sin.delete();
      set_req(3, 0); cyc(); set_req(7, 0); cyc(); idle(); cyc(); cyc();
      chk("t2_ph3", obs_sin.size() > 0 ? obs_sin[0] : -99999, T[4]);
      chk("t2_ph7", obs_sin.size() > 1 ? obs_sin[1] : -99999, T[0]);

      // Phase write and advance colliding on bin 5.
      set_cfg(0, 5, 16'h0300); cyc();
      set_cfg(1, 5, 16'h1000); cyc(); idle();
      obs_sin.delete();
      set_cfg(1, 5, 16'h8000); set_req(5, 1); cyc(); idle();
      set_req(5, 1); cyc(); idle(); cyc(); cyc();
      chk("t3_old", obs_sin.size() > 0 ? obs_sin[0] : -99999, wave(16'h1000));
      chk("t3_new", obs_sin.size() > 1 ? obs_sin[1] : -99999, -T[0]);

      // sync overrides advances.
      for (int b = 0; b < 3; b++) begin set_cfg(0, b, 16'h0123 + b); cyc(); end
      idle();
      for (int i = 0; i < 6; i++) begin set_req(i % 3, 1); cyc(); end
      for (int b = 0; b < 3; b++) begin sync_i = 1; set_req(b, 1); cyc(); end
      idle(); obs_sin.delete(); obs_cos.delete();
      for (int b = 0; b < 3; b++) begin set_req(b, 0); cyc(); end
      idle(); cyc(); cyc();
      for (int b = 0; b < 3; b++) begin
         chk("t4_sin", obs_sin.size() > b ? obs_sin[b] : -99999, T[0]);
         chk("t4_cos", obs_cos.size() > b ? obs_cos[b] : -99999, T[255]);
      end

      // Out-of-range request and cfg write.
      obs_sin.delete(); obs_cos.delete();
      set_req(30, 1); set_cfg(0, 25, 16'h7777); cyc();
      set_req(30, 0); set_cfg(1, 25, 16'h5555); cyc(); idle(); cyc(); cyc();
      chk("t5_count", obs_sin.size(), 2);
      chk("t5_sin", obs_sin.size() > 0 ? obs_sin[0] : -99999, 0);
      chk("t5_cos", obs_cos.size() > 0 ? obs_cos[0] : -99999, 0);
      for (int b = 0; b < BINS; b++) begin set_req(b, 1); cyc(); end
      idle(); cyc(); cyc();

      // Reset with two requests in flight.
      obs_sin.delete();
      set_req(0, 1); cyc();
      rst_i = 0; set_req(1, 1); cyc();
      rst_i = 1; idle(); cyc(); cyc();
      chk("t6_dropped", obs_sin.size(), 0);
      for (int b = 0; b < BINS; b++) begin set_req(b, 1); cyc(); end
      idle(); cyc(); cyc();
      chk("t6_count", obs_sin.size(), BINS);
      for (int b = 0; b < BINS && b < obs_sin.size(); b++) chk("t6_zero", obs_sin[b], T[0]);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         idle();
         rst_i = ($urandom_range(0, 199) != 0);
         sync_i = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) < 8)
            set_req(($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23),
                    1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 3) == 0)
            set_cfg(1'($urandom_range(0, 2) == 0), $urandom_range(0, 27), int'($urandom_range(0, 65535)));
         cyc();
      end
      rst_i = 1; idle(); cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
